nco_lo: RTL and testbench

NCO_LO -- requirements
Module: nco_lo

---
 rtl/nco_lo.sv | 189 ++++++++++++++++++
 tb/tb_nco_lo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_lo.sv
// Purpose: 64-bit phase-accumulator LO with 1-bit I/Q outputs and a debounced, optionally gliding, increment.
// Latency: lo_i/lo_q are registered from the pre-edge accumulator (1 cycle); a new PLL_inc takes SETTLE_CYCLES edges to be accepted.
// Backpressure: none; PLL_inc is a level that is sampled every cycle and busy reports an increment change in progress.
// Optional feature: define NCO_GLIDE_EN to ramp inc_active toward an accepted increment instead of jumping to it.
module nco_lo #(
    parameter logic [63:0] RESET_INC     = 64'h1B1B1B1B1B1B1B1,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          GLIDE_SHIFT   = 4,
    parameter int          GLIDE_DIV     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] PLL_inc,
    input  logic        phase_clr,
    output logic        lo_i,
    output logic        lo_q,
    output logic [63:0] inc_active,
    output logic        busy
);

    // Out-of-range parameters are rejected at elaboration time.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("nco_lo: SETTLE_CYCLES must be within 1..255");
    end
    if (GLIDE_SHIFT < 1 || GLIDE_SHIFT > 16) begin : g_bad_shift
        $error("nco_lo: GLIDE_SHIFT must be within 1..16");
    end
    if (GLIDE_DIV < 1 || GLIDE_DIV > 65535) begin : g_bad_div
        $error("nco_lo: GLIDE_DIV must be within 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GLIDE  = 2'd2
    } state_t;

    // Acceptance happens on the edge where the candidate has been seen for
    // SETTLE_CYCLES consecutive cycles; cnt counts the cycles already seen.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] acc;
    logic [63:0] target;
    logic [63:0] target_nxt;
    logic [63:0] cand;
    logic [63:0] cand_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [63:0] inc_nxt;

`ifdef NCO_GLIDE_EN
    localparam logic [15:0]        PRESC_LAST = 16'(GLIDE_DIV - 1);
    localparam logic signed [64:0] GLIDE_LIM  = 65'sd1 <<< GLIDE_SHIFT;

    logic [15:0]        presc;
    logic [15:0]        presc_nxt;
    logic signed [64:0] delta;
    logic [63:0]        glide_step;
    logic               glide_small;

    // Distance to the accepted increment; a 65-bit signed difference so both
    // directions of travel are represented without wrap.
    assign delta       = $signed({1'b0, target}) - $signed({1'b0, inc_active});
    // Arithmetic shift keeps the step strictly inside |delta|, so the ramp
    // can never pass the target; mod-2^64 add is exact because of that.
    assign glide_step  = 64'(delta >>> GLIDE_SHIFT);
    assign glide_small = (delta < GLIDE_LIM) && (delta > -GLIDE_LIM);
`endif

    assign busy = (state != IDLE);

    // Next-state logic for the increment debounce (and glide) controller.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        inc_nxt    = inc_active;
`ifdef NCO_GLIDE_EN
        presc_nxt  = presc;
`endif
        case (state)
            IDLE: begin
                if (PLL_inc != target) begin
                    cand_nxt  = PLL_inc;
                    cnt_nxt   = 8'd1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (PLL_inc != cand) begin
                    // Request moved again: restart the stability count.
                    cand_nxt = PLL_inc;
                    cnt_nxt  = 8'd1;
                end else if (cnt >= SETTLE_LAST) begin
                    // Stable long enough. A request that went back to the
                    // old target is accepted too, which leaves inc_active alone.
                    target_nxt = cand;
`ifdef NCO_GLIDE_EN
                    presc_nxt  = '0;
                    state_nxt  = GLIDE;
`else
                    inc_nxt    = cand;
                    state_nxt  = IDLE;
`endif
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
`ifdef NCO_GLIDE_EN
            GLIDE: begin
                if (PLL_inc != target) begin
                    // New request interrupts the ramp; inc_active freezes.
                    cand_nxt  = PLL_inc;
                    cnt_nxt   = 8'd1;
                    state_nxt = SETTLE;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    if (glide_small) begin
                        inc_nxt   = target;
                        state_nxt = IDLE;
                    end else begin
                        inc_nxt = inc_active + glide_step;
                    end
                end else begin
                    presc_nxt = presc + 16'd1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Controller state registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= RESET_INC;
            cand       <= RESET_INC;
            cnt        <= 8'd0;
            inc_active <= RESET_INC;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            inc_active <= inc_nxt;
        end
    end

`ifdef NCO_GLIDE_EN
    // Glide prescaler; restarted on every entry into GLIDE.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= presc_nxt;
        end
    end
`endif

    // Phase accumulator, free-running modulo 2^64; phase_clr only zeroes the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (phase_clr) begin
            acc <= '0;
        end else begin
            acc <= acc + inc_active;
        end
    end

    // I/Q squares from the top two phase bits: I is the half-cycle bit,
    // Q leads by a quarter turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_i <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            lo_i <= acc[63];
            lo_q <= acc[63] ^ acc[62];
        end
    end

endmodule

// File: tb/tb_nco_lo.sv
// Bench for nco_lo: directed vectors, expected values queued per clock edge and
// checked by an independent monitor on the falling edge.
module tb_nco_lo;

    localparam logic [63:0] R   = 64'h1B1B1B1B1B1B1B1;
    localparam logic [63:0] Q62 = 64'h4000000000000000;
    localparam logic [63:0] V1  = 64'h104376A9DD10437;
    localparam logic [63:0] VA  = 64'h0123456789ABCDEF;
    localparam logic [63:0] VB  = 64'h0FEDCBA987654321;
    localparam logic [63:0] VH  = 64'h19c0268cf359c02;

    localparam int K_INC   = 0;
    localparam int K_BUSY  = 1;
    localparam int K_ACC   = 2;
    localparam int K_LOI   = 3;
    localparam int K_LOQ   = 4;
    localparam int K_QLOI  = 5;
    localparam int K_QLOQ  = 6;
    localparam int K_QACC  = 7;
    localparam int K_QINC  = 8;
    localparam int K_QBUSY = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phase_clr = 1'b0;
    logic        phase_clr_q = 1'b0;
    logic [63:0] pll_inc = R;
    logic [63:0] pll_inc_q = Q62;
    logic        lo_i, lo_q, busy;
    logic [63:0] inc_active;
    logic        q_lo_i, q_lo_q, q_busy;
    logic [63:0] q_inc;

    nco_lo #(.RESET_INC(R), .SETTLE_CYCLES(2), .GLIDE_SHIFT(4), .GLIDE_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .PLL_inc(pll_inc), .phase_clr(phase_clr),
        .lo_i(lo_i), .lo_q(lo_q), .inc_active(inc_active), .busy(busy)
    );

    nco_lo #(.RESET_INC(Q62), .SETTLE_CYCLES(2), .GLIDE_SHIFT(4), .GLIDE_DIV(4)) u_q (
        .clk(clk), .rst(rst), .PLL_inc(pll_inc_q), .phase_clr(phase_clr_q),
        .lo_i(q_lo_i), .lo_q(q_lo_q), .inc_active(q_inc), .busy(q_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    int   wait_n = 0;

    function automatic string kname(input int k);
        case (k)
            K_INC:   return "inc_active";
            K_BUSY:  return "busy";
            K_ACC:   return "acc";
            K_LOI:   return "lo_i";
            K_LOQ:   return "lo_q";
            K_QLOI:  return "q.lo_i";
            K_QLOQ:  return "q.lo_q";
            K_QACC:  return "q.acc";
            K_QINC:  return "q.inc_active";
            default: return "q.busy";
        endcase
    endfunction

    function automatic logic [63:0] act_of(input int k);
        case (k)
            K_INC:   return inc_active;
            K_BUSY:  return {63'b0, busy};
            K_ACC:   return u_dut.acc;
            K_LOI:   return {63'b0, lo_i};
            K_LOQ:   return {63'b0, lo_q};
            K_QLOI:  return {63'b0, q_lo_i};
            K_QLOQ:  return {63'b0, q_lo_q};
            K_QACC:  return u_q.acc;
            K_QINC:  return q_inc;
            default: return {63'b0, q_busy};
        endcase
    endfunction

    // Monitor: checks every expectation due at the edge just passed.
    exp_t        me;
    logic [63:0] mact;
    always @(negedge clk) begin
        while (sbq.size() > 0 && (sbq[0].cyc <= cyc || done)) begin
            me   = sbq.pop_front();
            mact = act_of(me.kind);
            n_chk++;
            if (me.cyc != cyc || mact !== me.val) begin
                n_fail++;
                $display("FAIL %s edge=%0d (at %0d) got=%h want=%h",
                         kname(me.kind), me.cyc, cyc, mact, me.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Immediate comparison of a signal against its expected value.
    task automatic check_now(input int kind, input logic [63:0] val);
        logic [63:0] a;
        a = act_of(kind);
        n_chk++;
        if (a !== val) begin
            n_fail++;
            $display("FAIL %s (immediate at %0d) got=%h want=%h", kname(kind), cyc, a, val);
        end
    endtask

    // Expectation for the state right after the next rising edge.
    task automatic push(input int kind, input logic [63:0] val);
        exp_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic push_state(input logic [63:0] inc, input logic b);
        push(K_INC, inc);
        push(K_BUSY, {63'b0, b});
    endtask

    logic [63:0] m_acc;
    logic [63:0] ta [4];
    logic        ti [4];
    logic        tq [4];
`ifdef NCO_GLIDE_EN
    logic [63:0] tgt;
    logic [63:0] m_inc;
    logic [63:0] d;
    int          ph;
    bit          snapped;
`endif

    initial begin
        ta[0] = Q62; ta[1] = 64'h8000000000000000; ta[2] = 64'hC000000000000000; ta[3] = 64'h0;
        ti[0] = 1'b0; ti[1] = 1'b0; ti[2] = 1'b1; ti[3] = 1'b1;
        tq[0] = 1'b0; tq[1] = 1'b1; tq[2] = 1'b1; tq[3] = 1'b0;

        // Reset state.
        step();
        check_now(K_INC, R);
        check_now(K_BUSY, 64'h0);
        check_now(K_ACC, 64'h0);
        check_now(K_LOI, 64'h0);
        check_now(K_LOQ, 64'h0);
        push_state(R, 1'b0);
        push(K_ACC, 64'h0); push(K_LOI, 64'h0); push(K_LOQ, 64'h0);
        push(K_QLOI, 64'h0); push(K_QLOQ, 64'h0); push(K_QACC, 64'h0);
        push(K_QINC, Q62); push(K_QBUSY, 64'h0);
        step();
        rst = 1'b0;

        // Steady accumulation with the reset increment for 100 cycles.
        m_acc = '0;
        for (int k = 0; k < 100; k++) begin
            push(K_LOI, {63'b0, m_acc[63]});
            push(K_LOQ, {63'b0, m_acc[63] ^ m_acc[62]});
            m_acc = m_acc + R;
            push(K_ACC, m_acc);
            push_state(R, 1'b0);
            step();
        end

        // Phase clear on both instances; quadrature pattern and wrap on u_q.
        phase_clr = 1'b1; phase_clr_q = 1'b1;
        push(K_ACC, 64'h0); push(K_QACC, 64'h0); push_state(R, 1'b0);
        step();
        phase_clr = 1'b0; phase_clr_q = 1'b0;
        m_acc = '0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 4; j++) begin
                push(K_QLOI, {63'b0, ti[j]});
                push(K_QLOQ, {63'b0, tq[j]});
                push(K_QACC, ta[j]);
                m_acc = m_acc + R;
                push(K_ACC, m_acc);
                step();
            end
        end

`ifndef NCO_GLIDE_EN
        // Single change: busy from E0, inc_active updates at E1.
        pll_inc = V1;
        push_state(R, 1'b1);  step();
        push_state(V1, 1'b0); step();
        push_state(V1, 1'b0); step();

        // Chattering request, then a stable one.
        for (int i = 0; i < 20; i++) begin
            pll_inc = (i % 2 == 0) ? VA : VB;
            push_state(V1, 1'b1);
            step();
        end
        pll_inc = VH;
        push_state(V1, 1'b1); step();
        push_state(VH, 1'b0); step();
        push_state(VH, 1'b0); step();

        // Request bounces back to the current target before acceptance.
        pll_inc = VA;
        push_state(VH, 1'b1); step();
        pll_inc = VH;
        push_state(VH, 1'b1); step();
        push_state(VH, 1'b0); step();
        push_state(VH, 1'b0); step();

        // Reset together with phase_clr in the middle of SETTLE.
        pll_inc = VA;
        push_state(VH, 1'b1); step();
        rst = 1'b1; phase_clr = 1'b1;
        push_state(R, 1'b0);
        push(K_ACC, 64'h0); push(K_LOI, 64'h0); push(K_LOQ, 64'h0);
        step();
        rst = 1'b0; phase_clr = 1'b0; pll_inc = R;
        m_acc = '0;
        for (int i = 0; i < 4; i++) begin
            m_acc = m_acc + R;
            push(K_ACC, m_acc);
            push_state(R, 1'b0);
            step();
        end
`else
        // Glide toward RESET_INC + 2^20: first step +2^16 four clocks after GLIDE entry.
        tgt = R + 64'h100000;
        pll_inc = tgt;
        push_state(R, 1'b1); step();
        push_state(R, 1'b1); step();
        for (int i = 0; i < 3; i++) begin
            push_state(R, 1'b1);
            step();
        end
        m_inc = R + 64'h10000;
        push_state(m_inc, 1'b1); step();
        ph = 0; snapped = 1'b0;
        for (int n = 0; n < 4000 && !snapped; n++) begin
            ph++;
            if (ph == 4) begin
                ph = 0;
                d = tgt - m_inc;
                if (d < 64'd16) begin
                    m_inc = tgt;
                    snapped = 1'b1;
                    push_state(tgt, 1'b0);
                end else begin
                    m_inc = m_inc + (d >> 4);
                    push_state(m_inc, 1'b1);
                end
            end else begin
                push_state(m_inc, 1'b1);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            push_state(tgt, 1'b0);
            step();
        end

        // Reset together with phase_clr in the middle of a glide.
        pll_inc = R + 64'h1000000;
        for (int i = 0; i < 12; i++) begin
            push(K_BUSY, 64'h1);
            step();
        end
        rst = 1'b1; phase_clr = 1'b1;
        push_state(R, 1'b0);
        push(K_ACC, 64'h0); push(K_LOI, 64'h0); push(K_LOQ, 64'h0);
        step();
        rst = 1'b0; phase_clr = 1'b0; pll_inc = R;
        for (int i = 0; i < 12; i++) begin
            push_state(R, 1'b0);
            step();
        end
`endif

        // Bounded wait for the controller to be idle.
        wait_n = 0;
        while (busy !== 1'b0 && wait_n < 64) begin
            step();
            wait_n++;
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: busy still high after %0d cycles", wait_n);
        end

        step();
        done = 1'b1;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
